// File: rtl/if_fetch_stage_if.sv
// Interface bundle between the fetch stage, its hazard/branch controls, the
// instruction ROM and the IF/ID pipeline register consumers.
interface if_fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] im_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc8;
  logic        ifid_valid;
  logic        ifid_fetch_err;
  logic        redirect_pending;

  modport master (
    input  stall, flush, redirect, redirect_pc, im_instr,
    output pc, ifid_instr, ifid_pc, ifid_pc8, ifid_valid, ifid_fetch_err,
           redirect_pending
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, im_instr,
    input  pc, ifid_instr, ifid_pc, ifid_pc8, ifid_valid, ifid_fetch_err,
           redirect_pending
  );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, buffers redirects seen while
// stalled, and loads the IF/ID register with the fetched word or a bubble.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  if_fetch_stage_if.master bus
);

  // One bit wider so a window ending exactly at 2^32 still compares correctly.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  function automatic logic addr_fault(input logic [31:0] addr);
    addr_fault = (addr[1:0] != 2'b00) || (addr < IM_BASE) ||
                 ({1'b0, addr} >= IM_END);
  endfunction

  logic [31:0] pc_r;
  logic [31:0] pend_pc_r;
  logic        pend_r;
  logic [31:0] ifid_instr_r;
  logic [31:0] ifid_pc_r;
  logic [31:0] ifid_pc8_r;
  logic        ifid_valid_r;
  logic        ifid_err_r;

  logic        fetch_err_s;
  logic [31:0] fw_s;
  logic [31:0] pc_nxt_s;
  logic [31:0] pend_pc_nxt_s;
  logic        pend_nxt_s;
  logic [31:0] ifid_instr_nxt_s;
  logic [31:0] ifid_pc_nxt_s;
  logic [31:0] ifid_pc8_nxt_s;
  logic        ifid_valid_nxt_s;
  logic        ifid_err_nxt_s;

  // Fetch-error detection and NOP substitution for the word at pc.
  always_comb begin
    fetch_err_s = addr_fault(pc_r);
    if (fetch_err_s) begin
      fw_s = NOP_WORD;
    end else begin
      fw_s = bus.im_instr;
    end
  end

  // Next PC and redirect buffer; a stalled redirect is parked, newest wins.
  always_comb begin
    pc_nxt_s      = pc_r;
    pend_pc_nxt_s = pend_pc_r;
    pend_nxt_s    = pend_r;
    if (bus.stall) begin
      if (bus.redirect) begin
        pend_pc_nxt_s = bus.redirect_pc;
        pend_nxt_s    = 1'b1;
      end else begin
        pend_nxt_s    = pend_r;
      end
    end else if (bus.redirect) begin
      pc_nxt_s   = bus.redirect_pc;
      pend_nxt_s = 1'b0;
    end else if (pend_r) begin
      pc_nxt_s   = pend_pc_r;
      pend_nxt_s = 1'b0;
    end else begin
      pc_nxt_s   = pc_r + 32'd4;
    end
  end

  // IF/ID next value; flush still records pc so a faulting PC stays traceable.
  always_comb begin
    ifid_instr_nxt_s = ifid_instr_r;
    ifid_pc_nxt_s    = ifid_pc_r;
    ifid_pc8_nxt_s   = ifid_pc8_r;
    ifid_valid_nxt_s = ifid_valid_r;
    ifid_err_nxt_s   = ifid_err_r;
    if (bus.flush) begin
      ifid_instr_nxt_s = NOP_WORD;
      ifid_pc_nxt_s    = pc_r;
      ifid_pc8_nxt_s   = pc_r + 32'd8;
      ifid_valid_nxt_s = 1'b0;
      ifid_err_nxt_s   = 1'b0;
    end else if (!bus.stall) begin
      ifid_instr_nxt_s = fw_s;
      ifid_pc_nxt_s    = pc_r;
      ifid_pc8_nxt_s   = pc_r + 32'd8;
      ifid_valid_nxt_s = 1'b1;
      ifid_err_nxt_s   = fetch_err_s;
    end else begin
      ifid_valid_nxt_s = ifid_valid_r;
    end
  end

  // State registers for PC, redirect buffer and IF/ID.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r         <= PC_RESET;
      pend_pc_r    <= 32'h0000_0000;
      pend_r       <= 1'b0;
      ifid_instr_r <= NOP_WORD;
      ifid_pc_r    <= PC_RESET;
      ifid_pc8_r   <= PC_RESET + 32'd8;
      ifid_valid_r <= 1'b0;
      ifid_err_r   <= 1'b0;
    end else begin
      pc_r         <= pc_nxt_s;
      pend_pc_r    <= pend_pc_nxt_s;
      pend_r       <= pend_nxt_s;
      ifid_instr_r <= ifid_instr_nxt_s;
      ifid_pc_r    <= ifid_pc_nxt_s;
      ifid_pc8_r   <= ifid_pc8_nxt_s;
      ifid_valid_r <= ifid_valid_nxt_s;
      ifid_err_r   <= ifid_err_nxt_s;
    end
  end

  assign bus.pc               = pc_r;
  assign bus.ifid_instr       = ifid_instr_r;
  assign bus.ifid_pc          = ifid_pc_r;
  assign bus.ifid_pc8         = ifid_pc8_r;
  assign bus.ifid_valid       = ifid_valid_r;
  assign bus.ifid_fetch_err   = ifid_err_r;
  assign bus.redirect_pending = pend_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, a reset-while-pending
// sequence, and randomized traffic against a queue-based reference model.
module tb_if_fetch_stage;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    rom = (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign bus.im_instr = rom(bus.pc);

  function automatic logic bad_addr(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    bad_addr = !((x % 64'd4 == 64'd0) && (x >= 64'h3000) && (x < 64'h3000 + 64'd4 * 64'd4096));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic [31:0] e_ifid_pc;
    logic        e_valid;
    logic        e_err;
    logic        e_pend;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic r,
                              input logic [31:0] rpc, input logic [31:0] pc,
                              input logic [31:0] ipc, input logic v,
                              input logic e, input logic p);
    vec_t t;
    t.stall = s; t.flush = f; t.redirect = r; t.rpc = rpc;
    t.e_pc = pc; t.e_ifid_pc = ipc; t.e_valid = v; t.e_err = e; t.e_pend = p;
    return t;
  endfunction

  task automatic check_all(input string tag, input logic [31:0] pc,
                           input logic [31:0] ipc, input logic v,
                           input logic e, input logic p);
    logic [31:0] ins;
    ins = (v && !e) ? rom(ipc) : 32'h0000_0000;
    chk({tag, ".pc"}, bus.pc, pc);
    chk({tag, ".ifid_pc"}, bus.ifid_pc, ipc);
    chk({tag, ".ifid_pc8"}, bus.ifid_pc8, ipc + 32'd8);
    chk({tag, ".ifid_instr"}, bus.ifid_instr, ins);
    chk({tag, ".ifid_valid"}, {31'd0, bus.ifid_valid}, {31'd0, v});
    chk({tag, ".ifid_err"}, {31'd0, bus.ifid_fetch_err}, {31'd0, e});
    chk({tag, ".pending"}, {31'd0, bus.redirect_pending}, {31'd0, p});
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    bus.stall = s; bus.flush = f; bus.redirect = r; bus.redirect_pc = rpc;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: a pending redirect is a queue holding at most one target.
  logic [31:0] m_pc, m_ipc, m_ipc8, m_instr;
  logic        m_valid, m_err;
  logic [31:0] m_pend[$];

  task automatic model_reset();
    m_pc = 32'h3000; m_ipc = 32'h3000; m_ipc8 = 32'h3008; m_instr = 32'h0;
    m_valid = 1'b0; m_err = 1'b0; m_pend.delete();
  endtask

  task automatic model_step(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    logic e;
    e = bad_addr(m_pc);
    if (f) begin
      m_instr = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_ipc = m_pc; m_ipc8 = m_pc + 32'd8;
    end else if (!s) begin
      m_instr = e ? 32'h0 : rom(m_pc); m_valid = 1'b1; m_err = e;
      m_ipc = m_pc; m_ipc8 = m_pc + 32'd8;
    end
    if (s) begin
      if (r) begin
        m_pend.delete();
        m_pend.push_back(rpc);
      end
    end else if (r) begin
      m_pc = rpc;
      m_pend.delete();
    end else if (m_pend.size() != 0) begin
      m_pc = m_pend.pop_front();
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  vec_t vecs[26];

  initial begin
    errors = 0;
    checks = 0;
    vecs[0]  = mk(0,0,0,32'h0,        32'h3004, 32'h3000, 1,0,0);
    vecs[1]  = mk(0,0,0,32'h0,        32'h3008, 32'h3004, 1,0,0);
    vecs[2]  = mk(1,0,0,32'h0,        32'h3008, 32'h3004, 1,0,0);
    vecs[3]  = mk(1,0,0,32'h0,        32'h3008, 32'h3004, 1,0,0);
    vecs[4]  = mk(0,0,0,32'h0,        32'h300C, 32'h3008, 1,0,0);
    vecs[5]  = mk(0,0,0,32'h0,        32'h3010, 32'h300C, 1,0,0);
    vecs[6]  = mk(1,0,1,32'h3100,     32'h3010, 32'h300C, 1,0,1);
    vecs[7]  = mk(1,0,1,32'h3200,     32'h3010, 32'h300C, 1,0,1);
    vecs[8]  = mk(0,0,0,32'h0,        32'h3200, 32'h3010, 1,0,0);
    vecs[9]  = mk(0,0,0,32'h0,        32'h3204, 32'h3200, 1,0,0);
    vecs[10] = mk(1,0,1,32'h3100,     32'h3204, 32'h3200, 1,0,1);
    vecs[11] = mk(0,0,1,32'h3400,     32'h3400, 32'h3204, 1,0,0);
    vecs[12] = mk(0,0,0,32'h0,        32'h3404, 32'h3400, 1,0,0);
    vecs[13] = mk(1,1,0,32'h0,        32'h3404, 32'h3404, 0,0,0);
    vecs[14] = mk(0,0,0,32'h0,        32'h3408, 32'h3404, 1,0,0);
    vecs[15] = mk(0,0,1,32'h3002,     32'h3002, 32'h3408, 1,0,0);
    vecs[16] = mk(0,0,0,32'h0,        32'h3006, 32'h3002, 1,1,0);
    vecs[17] = mk(0,0,1,32'h2FFC,     32'h2FFC, 32'h3006, 1,1,0);
    vecs[18] = mk(0,0,1,32'h7000,     32'h7000, 32'h2FFC, 1,1,0);
    vecs[19] = mk(0,0,0,32'h0,        32'h7004, 32'h7000, 1,1,0);
    vecs[20] = mk(0,0,1,32'h6FFC,     32'h6FFC, 32'h7004, 1,1,0);
    vecs[21] = mk(0,0,0,32'h0,        32'h7000, 32'h6FFC, 1,0,0);
    vecs[22] = mk(0,0,1,32'hFFFF_FFFC,32'hFFFF_FFFC, 32'h7000, 1,1,0);
    vecs[23] = mk(0,0,0,32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 1,1,0);
    vecs[24] = mk(0,0,0,32'h0,        32'h0000_0004, 32'h0000_0000, 1,1,0);
    vecs[25] = mk(0,1,0,32'h0,        32'h0000_0008, 32'h0000_0004, 0,0,0);

    drive(0, 0, 0, 32'h0);
    reset = 1'b0;
    #12;
    check_all("reset", 32'h3000, 32'h3000, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].rpc);
      edge_wait();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifid_pc,
                vecs[i].e_valid, vecs[i].e_err, vecs[i].e_pend);
    end

    // Reset mid-cycle while a redirect is buffered: buffer must be discarded.
    drive(1, 0, 1, 32'h3500);
    edge_wait();
    chk("pend_before_reset", {31'd0, bus.redirect_pending}, 32'd1);
    drive(0, 0, 0, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check_all("async_reset", 32'h3000, 32'h3000, 0, 0, 0);
    #2;
    reset = 1'b1;
    edge_wait();
    check_all("post_reset", 32'h3004, 32'h3000, 1, 0, 0);

    // Randomized traffic against the reference model.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic s, f, r;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0:       t = 32'h3000 + 32'd4 * 32'($urandom_range(0, 4095));
        1:       t = 32'h3000 + 32'($urandom_range(0, 16383));
        2:       t = 32'h2FF0 + 32'd4 * 32'($urandom_range(0, 7));
        3:       t = 32'h6FF0 + 32'd4 * 32'($urandom_range(0, 7));
        4:       t = 32'hFFFF_FFF0 + 32'd4 * 32'($urandom_range(0, 3));
        default: t = 32'h3000 + 32'd4 * 32'($urandom_range(4090, 4095));
      endcase
      drive(s, f, r, t);
      model_step(s, f, r, t);
      edge_wait();
      chk("rnd.pc", bus.pc, m_pc);
      chk("rnd.ifid_pc", bus.ifid_pc, m_ipc);
      chk("rnd.ifid_pc8", bus.ifid_pc8, m_ipc8);
      chk("rnd.ifid_instr", bus.ifid_instr, m_instr);
      chk("rnd.ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, m_valid});
      chk("rnd.ifid_err", {31'd0, bus.ifid_fetch_err}, {31'd0, m_err});
      chk("rnd.pending", {31'd0, bus.redirect_pending}, {31'd0, (m_pend.size() != 0)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
